inst_fetch: RTL and testbench

Instruction fetch stage for the single-issue RV32I core. It owns the program counter, issues word fetches to instruction memory over a valid/ready request channel, and buffers in-order responses in a small FIFO. It presents one instruction per handshake to decode, where `if_opcode` drives the main control decoder. Branch/jump redirects flush the buffer and discard responses that are still in flight.

---
 rtl/riscv_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 58 +++++
 rtl/inst_fetch.sv | 100 ++++++++++
 tb/tb_inst_fetch.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I constants: datapath width, canonical NOP and the major opcodes
// decoded by the control unit downstream of fetch.
package riscv_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular FIFO with synchronous flush and occupancy count. Used both for
// buffered {pc, instr} responses and for the PCs of in-flight fetches.
module fetch_fifo #(
    parameter  int DEPTH = 3,
    parameter  int W     = 64,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic [W-1:0]  i_data,
    input  logic          i_pop,
    input  logic          i_flush,
    output logic [W-1:0]  o_data,
    output logic [CW-1:0] o_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_rd;
    logic [PW-1:0] r_wr;
    logic [CW-1:0] r_cnt;
    logic          w_push;
    logic          w_pop;

    // Overflow/underflow are dropped rather than corrupting the pointers.
    assign w_push = i_push && (r_cnt != CW'(DEPTH));
    assign w_pop  = i_pop  && (r_cnt != '0);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else if (i_flush) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= ptr_inc(r_wr);
            if (w_pop)  r_rd <= ptr_inc(r_rd);
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !i_flush) r_mem[r_wr] <= i_data;
    end

    assign o_data  = r_mem[r_rd];
    assign o_count = r_cnt;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: owns the PC, issues credit-limited word fetches, buffers
// in-order responses and squashes in-flight fetches on a redirect.
module inst_fetch #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              BUF_DEPTH = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr,
    output logic [6:0]      if_opcode
);

    import riscv_pkg::*;

    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam int SW = CW + 1;

    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_last_pc;
    logic [CW-1:0]     r_stale;
    logic [CW-1:0]     w_outst;
    logic [CW-1:0]     w_count;
    logic [XLEN-1:0]   w_rsp_pc;
    logic [2*XLEN-1:0] w_head;
    logic              w_empty;
    logic              w_credit;
    logic              w_req_valid;
    logic              w_req_fire;
    logic              w_rsp;
    logic              w_push;
    logic              w_pop;

    // Occupancy of the in-flight PC queue is the outstanding-request count.
    fetch_fifo #(.DEPTH(BUF_DEPTH), .W(XLEN)) u_pcq (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_req_fire),
        .i_data  (r_pc),
        .i_pop   (w_rsp),
        .i_flush (1'b0),
        .o_data  (w_rsp_pc),
        .o_count (w_outst)
    );

    fetch_fifo #(.DEPTH(BUF_DEPTH), .W(2 * XLEN)) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  ({w_rsp_pc, imem_rsp_data}),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .o_data  (w_head),
        .o_count (w_count)
    );

    assign w_empty     = (w_count == '0);
    assign w_credit    = ({1'b0, w_outst} + {1'b0, w_count}) < SW'(BUF_DEPTH);
    assign w_req_valid = rst_n && w_credit && !redirect_valid;
    assign w_req_fire  = w_req_valid && imem_req_ready;
    assign w_rsp       = imem_rsp_valid && (w_outst != '0);
    // Stale responses and any response landing in a redirect cycle are dropped.
    assign w_push      = w_rsp && (r_stale == '0) && !redirect_valid;
    assign w_pop       = !w_empty && if_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc      <= RESET_PC;
            r_stale   <= '0;
            r_last_pc <= '0;
        end else begin
            if (redirect_valid)  r_pc <= {redirect_pc[XLEN-1:2], 2'b00};
            else if (w_req_fire) r_pc <= r_pc + XLEN'(4);

            // Every fetch still in flight after this cycle belongs to the old path.
            if (redirect_valid)                r_stale <= w_outst - CW'(w_rsp);
            else if (w_rsp && r_stale != '0)   r_stale <= r_stale - CW'(1);

            if (!w_empty) r_last_pc <= w_head[2*XLEN-1:XLEN];
        end
    end

    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = r_pc;
    assign if_valid       = !w_empty;
    assign if_pc          = w_empty ? r_last_pc : w_head[2*XLEN-1:XLEN];
    assign if_instr       = w_empty ? XLEN'(NOP_INSTR) : w_head[XLEN-1:0];
    assign if_opcode      = if_instr[6:0];

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a behavioural in-order instruction memory.
module tb_inst_fetch;

    typedef struct { logic [31:0] pc; logic [31:0] ins; } pop_t;
    typedef struct { logic [31:0] addr; int due; } pend_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic [6:0]  if_opcode;

    pop_t        got_q[$];
    logic [31:0] acc_q[$];
    pend_t       pend_q[$];
    int          total = 0;
    int          bad = 0;
    int          mcyc = 0;
    int          m_lat = 1;
    bit          m_rand = 1'b0;
    int          max_infl = 0;

    inst_fetch #(.XLEN(32), .RESET_PC(32'h0), .BUF_DEPTH(3)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .if_opcode      (if_opcode)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[29:2], 4'b0011};
    endfunction

    function automatic logic [31:0] gpc(input int i);
        return (i < got_q.size()) ? got_q[i].pc : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] gacc(input int i);
        return (i < acc_q.size()) ? acc_q[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Leaves the bench 1 time unit into the first cycle after reset release (C0).
    task automatic do_reset(input bit rdy);
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        if_ready       = rdy;
        repeat (2) @(posedge clk);
        #1;
        acc_q.delete();
        got_q.delete();
        max_infl = 0;
        rst_n    = 1'b1;
    endtask

    // In-order memory: handshakes sampled mid-cycle, responses driven after the edge.
    initial begin : mem
        pend_t       e;
        bit          fire;
        logic [31:0] a;
        int          lat;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            fire = imem_req_valid && imem_req_ready;
            a    = imem_req_addr;
            if (fire) acc_q.push_back(a);
            @(posedge clk);
            #2;
            mcyc++;
            if (!rst_n) begin
                pend_q.delete();
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = '0;
            end else begin
                if (imem_rsp_valid && pend_q.size() > 0) void'(pend_q.pop_front());
                if (fire) begin
                    lat    = m_rand ? int'($urandom_range(1, 4)) : m_lat;
                    e.addr = a;
                    e.due  = mcyc + lat - 1;
                    pend_q.push_back(e);
                end
                imem_req_ready = m_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
                imem_rsp_valid = (pend_q.size() > 0) && (pend_q[0].due <= mcyc);
                imem_rsp_data  = imem_rsp_valid ? instr_of(pend_q[0].addr) : '0;
            end
        end
    end

    initial begin : mon
        pop_t p;
        forever begin
            @(negedge clk);
            if (rst_n && if_valid && if_ready) begin
                p.pc  = if_pc;
                p.ins = if_instr;
                got_q.push_back(p);
            end
        end
    end

    // Without redirects, accepted minus decoded equals outstanding plus buffered.
    initial begin : infl
        int n;
        forever begin
            @(posedge clk);
            #3;
            if (rst_n) begin
                n = acc_q.size() - got_q.size();
                if (n > max_infl) max_infl = n;
            end
        end
    end

    initial begin
        rst_n          = 1'b0;
        if_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        // Reset values
        smp();
        chk("rst_req_v", imem_req_valid, 0);
        chk("rst_addr",  imem_req_addr, 32'h0);
        chk("rst_if_v",  if_valid, 0);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_instr", if_instr, 32'h0000_0013);
        chk("rst_opc",   if_opcode, 7'h13);

        // Streaming with 1-cycle memory
        m_lat = 1;
        do_reset(1'b1);
        smp();
        chk("t1_c0_v",    imem_req_valid, 1);
        chk("t1_c0_addr", imem_req_addr, 32'h0);
        chk("t1_c0_if",   if_valid, 0);
        tick(); smp();
        chk("t1_c1_addr", imem_req_addr, 32'h4);
        chk("t1_c1_if",   if_valid, 0);
        tick(); smp();
        chk("t1_c2_addr", imem_req_addr, 32'h8);
        chk("t1_c2_if",   if_valid, 1);
        chk("t1_c2_pc",   if_pc, 32'h0);
        chk("t1_c2_ins",  if_instr, instr_of(32'h0));
        chk("t1_c2_opc",  if_opcode, 7'h03);
        tick(); smp();
        chk("t1_c3_if",   if_valid, 1);
        chk("t1_c3_pc",   if_pc, 32'h4);
        tick(); smp();
        chk("t1_c4_if",   if_valid, 1);
        chk("t1_c4_pc",   if_pc, 32'h8);

        // Decode stalled: credit limits fetch to three words
        do_reset(1'b0);
        repeat (5) tick();
        chk("t2_nacc", acc_q.size(), 3);
        smp();
        chk("t2_req_v", imem_req_valid, 0);
        chk("t2_if_v",  if_valid, 1);
        chk("t2_if_pc", if_pc, 32'h0);
        tick();
        if_ready = 1'b1;
        repeat (10) tick();
        chk("t2_pop0", gpc(0), 32'h0);
        chk("t2_pop1", gpc(1), 32'h4);
        chk("t2_pop2", gpc(2), 32'h8);
        chk("t2_pop3", gpc(3), 32'hC);
        chk("t2_acc3", gacc(3), 32'hC);

        // Redirect with two fetches outstanding (3-cycle memory)
        m_lat = 3;
        do_reset(1'b1);
        tick(); tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        smp();
        chk("t3_redir_req_v", imem_req_valid, 0);
        tick();
        redirect_valid = 1'b0;
        smp();
        chk("t3_req_v",    imem_req_valid, 1);
        chk("t3_req_addr", imem_req_addr, 32'h100);
        repeat (12) tick();
        chk("t3_acc2", gacc(2), 32'h100);
        chk("t3_pop0", gpc(0), 32'h100);
        chk("t3_pop1", gpc(1), 32'h104);
        chk("t3_ins0", (got_q.size() > 0) ? got_q[0].ins : 32'hDEAD_BEEF, instr_of(32'h100));

        // Redirect coincident with a pop and a response
        m_lat = 1;
        do_reset(1'b1);
        tick(); tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        smp();
        chk("t4_pop_v",  if_valid, 1);
        chk("t4_pop_pc", if_pc, 32'h0);
        chk("t4_rsp_v",  imem_rsp_valid, 1);
        tick();
        redirect_valid = 1'b0;
        smp();
        chk("t4_empty",    if_valid, 0);
        chk("t4_req_addr", imem_req_addr, 32'h200);
        repeat (8) tick();
        chk("t4_pop0", gpc(0), 32'h0);
        chk("t4_pop1", gpc(1), 32'h200);
        chk("t4_pop2", gpc(2), 32'h204);

        // Asynchronous reset mid-stream with two buffered entries
        do_reset(1'b0);
        repeat (3) tick();
        #1;
        chk("t5_pre_v", if_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("t5_if_v",  if_valid, 0);
        chk("t5_instr", if_instr, 32'h0000_0013);
        chk("t5_if_pc", if_pc, 32'h0);
        chk("t5_req_v", imem_req_valid, 0);
        do_reset(1'b1);
        repeat (6) tick();
        chk("t5_acc0", gacc(0), 32'h0);
        chk("t5_pop0", gpc(0), 32'h0);
        chk("t5_pop1", gpc(1), 32'h4);

        // Random memory stalls and 1-4 cycle latency
        m_rand = 1'b1;
        do_reset(1'b1);
        repeat (300) begin
            tick();
            if_ready = ($urandom_range(0, 3) != 0);
        end
        m_rand   = 1'b0;
        if_ready = 1'b0;
        tick();
        chk("t6_progress", got_q.size() >= 20, 1);
        for (int i = 0; i < got_q.size(); i++) begin
            chk($sformatf("t6_pc%0d", i),  got_q[i].pc, 32'(i * 4));
            chk($sformatf("t6_ins%0d", i), got_q[i].ins, instr_of(got_q[i].pc));
        end
        chk("t6_max_infl", max_infl <= 3, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
